// File: rtl/prog_seq_pkg.sv
// rtl/prog_seq_pkg.sv - shared types, widths and address mapping for prog_sequencer
package prog_seq_pkg;

  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_NEXT,
    S_FINISH
  } seq_state_t;

  // Maps a program index to its ROM start PC.
  function automatic logic [ADDR_W-1:0] prog_addr(
    input logic [1:0]        idx,
    input logic [ADDR_W-1:0] a0,
    input logic [ADDR_W-1:0] a1,
    input logic [ADDR_W-1:0] a2,
    input logic [ADDR_W-1:0] a3
  );
    case (idx)
      2'd0:    return a0;
      2'd1:    return a1;
      2'd2:    return a2;
      default: return a3;
    endcase
  endfunction

endpackage

// File: rtl/prog_sequencer_sat_counter.sv
// rtl/prog_sequencer_sat_counter.sv - saturating up-counter with load-to-one
module sat_counter
  import prog_seq_pkg::*;
#(
  parameter int W = CNT_W
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load1,
  input  logic         i_en,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Load-1 starts a fresh count; enable advances it until it sticks at all-ones.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load1) begin
      r_count <= W'(1);
    end else if (i_en && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - launches each ROM program in turn and times its run
module prog_sequencer
  import prog_seq_pkg::*;
#(
  parameter int                NUM_PROGS  = 3,
  parameter logic [ADDR_W-1:0] PROG0_ADDR = 8'd0,
  parameter logic [ADDR_W-1:0] PROG1_ADDR = 8'd64,
  parameter logic [ADDR_W-1:0] PROG2_ADDR = 8'd128,
  parameter logic [ADDR_W-1:0] PROG3_ADDR = 8'd192,
  parameter int                START_HOLD = 2,
  parameter logic [CNT_W-1:0]  TIMEOUT    = 16'd4000
) (
  input  logic              CLK,
  input  logic              Reset_n,
  input  logic              Go,
  input  logic              Done,
  output logic              Start,
  output logic [ADDR_W-1:0] Start_Addr,
  output logic              Busy,
  output logic [1:0]        Prog_Idx,
  output logic [CNT_W-1:0]  Cycle_Count,
  output logic              Count_Valid,
  output logic              Timed_Out,
  output logic              All_Done
);

  localparam logic [1:0] LAST_IDX  = 2'(NUM_PROGS - 1);
  localparam logic [1:0] HOLD_LAST = 2'(START_HOLD - 1);

  seq_state_t        r_state, w_next_state;
  logic [1:0]        r_prog_idx, w_next_idx;
  logic [1:0]        r_hold;
  logic [CNT_W-1:0]  w_count;
  logic              w_load1, w_run_en, w_latch, w_timeout_hit;

  logic              r_start, r_busy, r_count_valid, r_timed_out, r_all_done;
  logic [ADDR_W-1:0] r_start_addr;
  logic [CNT_W-1:0]  r_cycle_count;

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .i_clk   (CLK),
    .i_rst_n (Reset_n),
    .i_load1 (w_load1),
    .i_en    (w_run_en),
    .o_count (w_count)
  );

  // Next-state, next program index and RUN-exit decisions.
  always_comb begin
    w_next_state  = r_state;
    w_next_idx    = r_prog_idx;
    w_latch       = 1'b0;
    w_timeout_hit = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_idx = 2'd0;
        if (Go) w_next_state = S_LAUNCH;
      end
      S_LAUNCH: begin
        if (r_hold == HOLD_LAST) w_next_state = S_RUN;
      end
      S_RUN: begin
        // Done takes priority so a program finishing on the timeout cycle is not flagged.
        if (Done) begin
          w_latch      = 1'b1;
          w_next_state = S_NEXT;
        end else if (w_count == TIMEOUT) begin
          w_latch       = 1'b1;
          w_timeout_hit = 1'b1;
          w_next_state  = S_NEXT;
        end
      end
      S_NEXT: begin
        if (r_prog_idx == LAST_IDX) begin
          w_next_state = S_FINISH;
        end else begin
          w_next_idx   = r_prog_idx + 2'd1;
          w_next_state = S_LAUNCH;
        end
      end
      S_FINISH: begin
        if (!Go) begin
          w_next_state = S_IDLE;
          w_next_idx   = 2'd0;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  assign w_load1  = (r_state == S_LAUNCH) && (w_next_state == S_RUN);
  assign w_run_en = (r_state == S_RUN);

  // State, program index and launch hold counter.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state    <= S_IDLE;
      r_prog_idx <= 2'd0;
      r_hold     <= 2'd0;
    end else begin
      r_state    <= w_next_state;
      r_prog_idx <= w_next_idx;
      r_hold     <= (r_state == S_LAUNCH) ? r_hold + 2'd1 : 2'd0;
    end
  end

  // Registered outputs, decoded from the upcoming state so they align with it.
  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      r_start       <= 1'b1;
      r_start_addr  <= PROG0_ADDR;
      r_busy        <= 1'b0;
      r_cycle_count <= '0;
      r_count_valid <= 1'b0;
      r_timed_out   <= 1'b0;
      r_all_done    <= 1'b0;
    end else begin
      r_start       <= (w_next_state != S_RUN);
      r_start_addr  <= prog_addr(w_next_idx, PROG0_ADDR, PROG1_ADDR, PROG2_ADDR, PROG3_ADDR);
      r_busy        <= (w_next_state == S_LAUNCH) || (w_next_state == S_RUN) ||
                       (w_next_state == S_NEXT);
      r_all_done    <= (w_next_state == S_FINISH);
      r_count_valid <= w_latch;
      if (w_latch) r_cycle_count <= w_count;
      if ((r_state == S_IDLE) && (w_next_state == S_LAUNCH)) begin
        r_timed_out <= 1'b0;
      end else if (w_timeout_hit) begin
        r_timed_out <= 1'b1;
      end
    end
  end

  assign Start       = r_start;
  assign Start_Addr  = r_start_addr;
  assign Busy        = r_busy;
  assign Prog_Idx    = r_prog_idx;
  assign Cycle_Count = r_cycle_count;
  assign Count_Valid = r_count_valid;
  assign Timed_Out   = r_timed_out;
  assign All_Done    = r_all_done;

endmodule

// File: tb/tb_prog_sequencer.sv
// tb/tb_prog_sequencer.sv - self-checking bench for prog_sequencer
module tb_prog_sequencer;

  localparam int HOLD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, go_drv, done_drv, sel;

  logic        a_go, a_done, a_start, a_busy, a_cv, a_to, a_ad;
  logic [7:0]  a_addr;
  logic [1:0]  a_idx;
  logic [15:0] a_cc;
  logic        b_go, b_done, b_start, b_busy, b_cv, b_to, b_ad;
  logic [7:0]  b_addr;
  logic [1:0]  b_idx;
  logic [15:0] b_cc;

  prog_sequencer #(.NUM_PROGS(3), .START_HOLD(HOLD), .TIMEOUT(16'd50)) dut_a (
    .CLK(clk), .Reset_n(rst_n), .Go(a_go), .Done(a_done),
    .Start(a_start), .Start_Addr(a_addr), .Busy(a_busy), .Prog_Idx(a_idx),
    .Cycle_Count(a_cc), .Count_Valid(a_cv), .Timed_Out(a_to), .All_Done(a_ad)
  );

  prog_sequencer #(.NUM_PROGS(1), .START_HOLD(HOLD)) dut_b (
    .CLK(clk), .Reset_n(rst_n), .Go(b_go), .Done(b_done),
    .Start(b_start), .Start_Addr(b_addr), .Busy(b_busy), .Prog_Idx(b_idx),
    .Cycle_Count(b_cc), .Count_Valid(b_cv), .Timed_Out(b_to), .All_Done(b_ad)
  );

  assign a_go   = sel ? 1'b0 : go_drv;
  assign a_done = sel ? 1'b0 : done_drv;
  assign b_go   = sel ? go_drv : 1'b0;
  assign b_done = sel ? done_drv : 1'b0;

  wire        m_start = sel ? b_start : a_start;
  wire [7:0]  m_addr  = sel ? b_addr  : a_addr;
  wire        m_busy  = sel ? b_busy  : a_busy;
  wire [1:0]  m_idx   = sel ? b_idx   : a_idx;
  wire [15:0] m_cc    = sel ? b_cc    : a_cc;
  wire        m_cv    = sel ? b_cv    : a_cv;
  wire        m_to    = sel ? b_to    : a_to;
  wire        m_ad    = sel ? b_ad    : a_ad;

  int checks = 0;
  int errors = 0;
  int addr_tbl[4] = '{0, 64, 128, 192};
  bit exp_to;
  int last_cnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_start"}, 32'(m_start), 32'd1);
    check({tag, "_addr"},  32'(m_addr),  32'd0);
    check({tag, "_busy"},  32'(m_busy),  32'd0);
    check({tag, "_idx"},   32'(m_idx),   32'd0);
    check({tag, "_cc"},    32'(m_cc),    32'd0);
    check({tag, "_cv"},    32'(m_cv),    32'd0);
    check({tag, "_to"},    32'(m_to),    32'd0);
    check({tag, "_ad"},    32'(m_ad),    32'd0);
  endtask

  // One program: launch window, then Done on RUN cycle d (0 = never). abort_at>0 resets mid-RUN.
  task automatic run_prog(input int k, input int d, input int abort_at, input int to_lim, input int n);
    int h, r, exp_cnt;
    logic [7:0] addr_seen;
    bit got;
    h = 0;
    addr_seen = '0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (m_start !== 1'b1) break;
      h++;
      addr_seen = m_addr;
      if (h == 1) check($sformatf("cv_low_p%0d", k), 32'(m_cv), 32'd0);
    end
    check($sformatf("hold_p%0d", k), 32'(h), 32'(HOLD));
    check($sformatf("addr_p%0d", k), 32'(addr_seen), 32'(addr_tbl[k]));
    check($sformatf("busy_run_p%0d", k), 32'(m_busy), 32'd1);
    if (k == 0) check("to_clear_on_go", 32'(m_to), 32'd0);
    r = 1;
    got = 1'b0;
    while (r < 200) begin
      if (abort_at == r) begin
        rst_n = 1'b0;
        #1;
        check_reset_vals("midrun_rst");
        return;
      end
      done_drv = (r == d);
      @(posedge clk); @(negedge clk);
      if (m_cv === 1'b1) begin
        got = 1'b1;
        break;
      end
      check($sformatf("run_start_p%0d", k), 32'(m_start), 32'd0);
      r++;
    end
    done_drv = 1'b0;
    exp_cnt = (d >= 1 && d <= to_lim) ? d : to_lim;
    if (!(d >= 1 && d <= to_lim)) exp_to = 1'b1;
    last_cnt = exp_cnt;
    check($sformatf("cv_seen_p%0d", k), 32'(got), 32'd1);
    check($sformatf("cc_p%0d", k), 32'(m_cc), 32'(exp_cnt));
    check($sformatf("run_len_p%0d", k), 32'(r), 32'(exp_cnt));
    check($sformatf("to_p%0d", k), 32'(m_to), 32'(exp_to));
    check($sformatf("idx_p%0d", k), 32'(m_idx), 32'(k));
    if (k < n - 1) check($sformatf("next_start_p%0d", k), 32'(m_start), 32'd1);
  endtask

  // Full sequence with Go held high throughout, then FINISH must persist while Go stays high.
  task automatic run_seq(input int n, input int d0, input int d1, input int d2, input int to_lim);
    int ds[3];
    ds = '{d0, d1, d2};
    go_drv = 1'b1;
    exp_to = 1'b0;
    for (int k = 0; k < n; k++) run_prog(k, ds[k], 0, to_lim, n);
    @(posedge clk); @(negedge clk);
    check("fin_ad",   32'(m_ad),    32'd1);
    check("fin_busy", 32'(m_busy),  32'd0);
    check("fin_cv",   32'(m_cv),    32'd0);
    check("fin_idx",  32'(m_idx),   32'(n - 1));
    check("fin_cc",   32'(m_cc),    32'(last_cnt));
    check("fin_to",   32'(m_to),    32'(exp_to));
    check("fin_start", 32'(m_start), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); @(negedge clk);
      check("fin_hold_ad", 32'(m_ad), 32'd1);
      check("fin_hold_busy", 32'(m_busy), 32'd0);
    end
  endtask

  task automatic go_idle();
    go_drv = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_ad",    32'(m_ad),    32'd0);
    check("idle_start", 32'(m_start), 32'd1);
    check("idle_busy",  32'(m_busy),  32'd0);
    check("idle_idx",   32'(m_idx),   32'd0);
    check("idle_addr",  32'(m_addr),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; go_drv = 1'b0; done_drv = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_vals("post_rel");

    sel = 1'b1;
    run_seq(1, 37, 0, 0, 4000);
    go_idle();

    sel = 1'b0;
    run_seq(3, 10, 20, 30, 50);
    go_idle();
    run_seq(3, 50, 8, 0, 50);
    go_idle();
    for (int it = 0; it < 4; it++) begin
      run_seq(3, int'($urandom_range(0, 60)), int'($urandom_range(0, 60)),
              int'($urandom_range(0, 60)), 50);
      go_idle();
    end

    go_drv = 1'b1;
    exp_to = 1'b0;
    run_prog(0, 5, 0, 50, 3);
    run_prog(1, 40, 12, 50, 3);
    go_drv = 1'b0;
    @(negedge clk);
    check_reset_vals("in_rst");
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check_reset_vals("after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Upstream run controller for the single-cycle core. It owns the core's `Start`/`Start_Addr` inputs and launches each program in the instruction ROM in turn. For each program it waits for the core's `Done` indication, or for a timeout, and reports a per-program cycle count. It replaces hand-driven start pulses in the testbench and sits between the bench/host `Go` control and the core top level.

## Interface
Parameters:
- `NUM_PROGS`, 3: number of programs run per sequence (1–4).
- `PROG0_ADDR`, 8'd0: start PC of program 0.
- `PROG1_ADDR`, 8'd64: start PC of program 1.
- `PROG2_ADDR`, 8'd128: start PC of program 2.
- `PROG3_ADDR`, 8'd192: start PC of program 3.
- `START_HOLD`, 2: cycles `Start` is held high per launch (≥1).
- `TIMEOUT`, 16'd4000: RUN cycles before a program is abandoned.

Ports:
- `CLK` in 1: single clock, all state on rising edge.
- `Reset_n` in 1: asynchronous, active-low reset.
- `Go` in 1: level request to run the full sequence.
- `Done` in 1: core finished current program (level, sampled in RUN only).
- `Start` out 1: drives core `start`; high holds the core PC at `Start_Addr`.
- `Start_Addr` out 8: drives core `start_addr`.
- `Busy` out 1: high in LAUNCH/RUN/NEXT.
- `Prog_Idx` out 2: index of current or last program.
- `Cycle_Count` out 16: latched RUN-cycle count of the last finished program.
- `Count_Valid` out 1: one-cycle pulse when `Cycle_Count` updates.
- `Timed_Out` out 1: sticky per sequence; set if any program hit `TIMEOUT`.
- `All_Done` out 1: high in FINISH.

## Operation
- States: IDLE, LAUNCH, RUN, NEXT, FINISH.
- IDLE:
  - `Start`=1, `Prog_Idx`=0, `Start_Addr`=`PROG0_ADDR`.
  - `Go`=1 → LAUNCH; `Timed_Out` is cleared on this transition.
- LAUNCH:
  - `Start`=1 and `Start_Addr`=address of `Prog_Idx`, both stable.
  - Hold counter runs `START_HOLD` cycles, then → RUN.
- RUN:
  - `Start`=0.
  - The cycle counter loads 1 on the first RUN cycle and increments each subsequent RUN cycle.
  - It saturates at 16'hFFFF.
  - `Done`=1 → latch counter into `Cycle_Count`, pulse `Count_Valid`, → NEXT.
  - Else if counter == `TIMEOUT` → latch, pulse `Count_Valid`, set `Timed_Out`, → NEXT.
  - `Done` and timeout in the same cycle: `Done` wins and `Timed_Out` is not set.
- NEXT:
  - `Start`=1 for one cycle.
  - If `Prog_Idx`==`NUM_PROGS`-1 → FINISH; else increment `Prog_Idx` → LAUNCH.
- FINISH:
  - `Start`=1, `All_Done`=1; `Prog_Idx` and `Cycle_Count` hold.
  - `Go`=0 → IDLE. `Go` held high does not restart the sequence; a restart needs `Go` low then high.
- `Go` falling during LAUNCH/RUN/NEXT is ignored; the sequence always completes.
- `Done` outside RUN is ignored.

## Timing
- Reset values (asynchronous assert, synchronous release):
  - State = IDLE.
  - `Start`=1, `Start_Addr`=`PROG0_ADDR`.
  - `Busy`=0, `Prog_Idx`=0.
  - `Cycle_Count`=0, `Count_Valid`=0.
  - `Timed_Out`=0, `All_Done`=0.
- All outputs are registered; no combinational path from inputs to outputs.
- Cycle timeline:
  - `Go` sampled high at edge N → `Start`/`Start_Addr` valid for launch from N+1.
  - First `Start`=0 cycle is N+1+`START_HOLD`.
- `Done` sampled high at RUN edge M:
  - `Cycle_Count` and `Count_Valid` are visible after edge M.
  - `Count_Valid` drops after edge M+1.
- `Cycle_Count` equals the number of RUN cycles up to and including the `Done`-sampling cycle.
- Reset mid-sequence: immediate return to IDLE values; any partial count is discarded.

## Structure
- `prog_seq_pkg` holds:
  - the state enum `seq_state_t`;
  - `ADDR_W`=8 and `CNT_W`=16 localparams;
  - a function mapping a program index to its start address.
- One sub-module, `sat_counter`: width-parameterised counter with load-1, enable and saturation. It is instanced once for the RUN counter; the LAUNCH hold counter is an inline 2-bit counter.
- Integration: at the top level, `start`/`start_addr` of the core come from this block, and `Done` is taken from the core's halt decode.

## Test plan
- Reset: assert `Reset_n`=0 mid-RUN of program 1 → all outputs return to their reset values that cycle, and `Start`=1.
- Single program: `NUM_PROGS`=1, `Go`=1, `Done` raised on the 37th RUN cycle → `Cycle_Count`=37, one `Count_Valid` pulse, `All_Done`=1, `Timed_Out`=0.
- Three programs, `Done` after 10/20/30 RUN cycles:
  - `Start_Addr` sequence 0/64/128;
  - `Start` high exactly 2 cycles per launch;
  - counts 10, 20, 30.
- Timeout: `TIMEOUT`=50, `Done` never asserted → `Cycle_Count`=50, `Timed_Out`=1, sequence advances to the next program.
- Simultaneous: `Done`=1 exactly on RUN cycle 50 with `TIMEOUT`=50 → `Cycle_Count`=50, `Timed_Out`=0.
- Re-run:
  - `Go` held high in FINISH → stays in FINISH.
  - `Go` low one cycle then high → relaunch at `PROG0_ADDR` with `Timed_Out` cleared.
